step_scheduler: RTL
===================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, move-queue depth in entries (power of 2, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port counter  input  32  free-running clock counter value (time base).
REQ-005 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  wishbone slave strobe, cycle and write-enable.
REQ-006 SHALL have ports wb_adr_i  input  4, wb_dat_i  input  32, wb_dat_o  output  32, and wb_ack_o  output  1.
REQ-007 SHALL have port shutdown  input  1  emergency stop.
REQ-008 SHALL have ports step  output  1, dir  output  1, and irq  output  1 (level interrupt).

Function
REQ-009 SHALL raise wb_ack_o for exactly one cycle, in the cycle after wb_stb_i&wb_cyc_i while wb_ack_o is low; every address acks.
REQ-010 SHALL drive wb_dat_o from registers at the ack cycle; unmapped addresses read 0 and ignore writes.
REQ-011 SHALL map register 0 CTRL: bit1 enable (RW), bit3 irq_en (RW), bit2 queue_empty (RO), bits[6:4] queue occupancy (RO), bit7 overflow (sticky; any CTRL write clears it).
REQ-012 SHALL map register 1 PULSE: bits[7:0] step high time in clk cycles; 0 is treated as 1; reset value 2.
REQ-013 SHALL map register 2 INTERVAL: 32-bit staging register for the next move's interval (RW).
REQ-014 SHALL map register 3 MOVE, write-only: bits[15:0] count, bits[30:16] signed add, bit31 dir; a write pushes {INTERVAL, count, add, dir} into the queue.
REQ-015 SHALL map register 4 LAST_TIME (RW): time of last step; a write is accepted only in IDLE.
REQ-016 SHALL map register 5 POSITION (RO): signed 32-bit step count, +1 per step with dir=0, -1 with dir=1, wrapping.
REQ-017 SHALL drop a MOVE push when the queue is full and set overflow; the queue is unchanged.
REQ-018 SHALL implement FSM states IDLE, LOAD, WAIT, PULSE.
REQ-019 SHALL transition IDLE->LOAD when enable=1 and the queue is non-empty.
REQ-020 SHALL, in LOAD, pop the head and latch dir output, count, add and interval; next_time = LAST_TIME + interval (mod 2^32) -> WAIT; an entry with count=0 is discarded -> IDLE.
REQ-021 SHALL, in WAIT, compare with due = (counter - next_time) interpreted as signed 32-bit >= 0 (wrap-safe); due -> step=1, LAST_TIME=next_time, count-1, POSITION update, interval += sign-extended add -> PULSE.
REQ-022 SHALL hold step high for exactly PULSE cycles, then drive step low.
REQ-023 SHALL, at the end of PULSE, go to WAIT with next_time = LAST_TIME + interval if count != 0; otherwise go to LOAD if enable and the queue is non-empty, else IDLE.
REQ-024 SHALL keep step low for at least one cycle between pulses, even when the next step is already due.
REQ-025 SHALL keep dir stable from LOAD through the end of the move; the first step occurs no earlier than the cycle after LOAD.
REQ-026 SHALL, when enable is cleared mid-move, finish the current move and then idle.
REQ-027 SHALL, while shutdown=1, flush the queue, force IDLE and step=0, clear enable, and ignore MOVE pushes (LAST_TIME and POSITION retained); a step in progress is cut short.
REQ-028 SHALL drive irq = irq_en & enable & queue_empty & (state==IDLE).
REQ-029 SHALL give a simultaneous push and pop in the same cycle a net occupancy of unchanged.

Reset
REQ-030 SHALL, on rst_n=0 at a clk edge, set state IDLE, step=0, dir=0, irq=0, wb_ack_o=0, wb_dat_o=0, queue empty, enable=0, irq_en=0, overflow=0, PULSE=2, and INTERVAL, LAST_TIME and POSITION = 0; reset mid-pulse drops step the next cycle.

Verification
REQ-031 SHALL be verified with: LAST_TIME=100, INTERVAL=50, MOVE count=3 add=0 dir=0, enable -> step rises when counter=150, 200, 250, each high 2 cycles; POSITION=3; irq after the last step when irq_en=1.
REQ-032 SHALL be verified with: INTERVAL=100, add=-10, count=4 -> step spacing 100, 90, 80, 70.
REQ-033 SHALL be verified with: LAST_TIME=0xFFFFFFF0, INTERVAL=0x20 -> step at counter=0x10 (wrap); dir=1 move -> POSITION decrements.
REQ-034 SHALL be verified with: 5 pushes, QDEPTH=4, enable=0 -> occupancy 4, overflow=1; a CTRL write clears overflow.
REQ-035 SHALL be verified with: shutdown pulsed mid-PULSE with 2 queued -> step=0 next cycle, queue_empty=1, enable=0, pushes ignored while high.
REQ-036 SHALL be verified with: back-to-back wishbone reads -> one ack per access, unmapped address 9 reads 0.

Source files
------------

// File: rtl/step_scheduler_if.sv
// step_scheduler_if: wishbone slave bus bundle for the step scheduler
interface step_scheduler_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  modport master (output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, input wb_dat_o, wb_ack_o);
  modport slave (input wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/step_scheduler.sv
// step_scheduler: queued stepper-motor move executor with wishbone register access
module step_scheduler #(
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      counter,
  input  logic             shutdown,
  step_scheduler_if.slave  wb,
  output logic             step,
  output logic             dir,
  output logic             irq
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(QDEPTH);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, PULSE = 2'd3;
  logic [63:0]   q [QDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   occ;
  logic [1:0]    state;
  logic          enable, irq_en, overflow;
  logic [7:0]    pulse_w, pulse_cnt;
  logic [31:0]   interval_reg, last_time, position, interval, next_time, rdata, diff;
  logic [15:0]   cnt;
  logic [14:0]   add;
  logic          acc, wr, empty, full, push, pop, due;
  logic [63:0]   head;
  assign acc   = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr    = acc & wb.wb_we_i;
  assign empty = occ == '0;
  assign full  = occ == FULL;
  assign push  = wr & (wb.wb_adr_i == 4'd3) & ~shutdown & ~full;
  assign pop   = state == LOAD;
  assign head  = q[rp];
  assign diff  = counter - next_time;
  assign due   = ~diff[31];
  assign irq   = irq_en & enable & empty & (state == IDLE);
  always_comb begin
    rdata = wb.wb_adr_i == 4'd0 ? {24'd0, overflow, 3'(occ), irq_en, empty, enable, 1'b0} :
            wb.wb_adr_i == 4'd1 ? {24'd0, pulse_w} :
            wb.wb_adr_i == 4'd2 ? interval_reg :
            wb.wb_adr_i == 4'd4 ? last_time :
            wb.wb_adr_i == 4'd5 ? position : 32'd0;
  end
  // queue entry: {interval[63:32], count[31:16], add[15:1], dir[0]}
  always_ff @(posedge clk) begin
    if (push) q[wp] <= {interval_reg, wb.wb_dat_i[15:0], wb.wb_dat_i[30:16], wb.wb_dat_i[31]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= 1'b0;
      dir          <= 1'b0;
      wb.wb_ack_o  <= 1'b0;
      wb.wb_dat_o  <= 32'd0;
      wp           <= '0;
      rp           <= '0;
      occ          <= '0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      overflow     <= 1'b0;
      pulse_w      <= 8'd2;
      pulse_cnt    <= 8'd0;
      interval_reg <= 32'd0;
      last_time    <= 32'd0;
      position     <= 32'd0;
      interval     <= 32'd0;
      next_time    <= 32'd0;
      cnt          <= 16'd0;
      add          <= 15'd0;
    end else begin
      wb.wb_ack_o <= acc;
      wb.wb_dat_o <= acc ? rdata : 32'd0;
      if (wr && wb.wb_adr_i == 4'd0) begin
        enable   <= wb.wb_dat_i[1];
        irq_en   <= wb.wb_dat_i[3];
        overflow <= 1'b0;
      end
      if (wr && wb.wb_adr_i == 4'd1) pulse_w <= wb.wb_dat_i[7:0];
      if (wr && wb.wb_adr_i == 4'd2) interval_reg <= wb.wb_dat_i;
      if (wr && wb.wb_adr_i == 4'd3 && full && !shutdown) overflow <= 1'b1;
      if (wr && wb.wb_adr_i == 4'd4 && state == IDLE) last_time <= wb.wb_dat_i;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      occ <= occ + (AW + 1)'(push) - (AW + 1)'(pop);
      case (state)
        IDLE: if (enable && !empty) state <= LOAD;
        LOAD: begin
          dir       <= head[0];
          add       <= head[15:1];
          cnt       <= head[31:16];
          interval  <= head[63:32];
          next_time <= last_time + head[63:32];
          state     <= head[31:16] == 16'd0 ? IDLE : WAIT;
        end
        WAIT: if (due) begin
          step      <= 1'b1;
          last_time <= next_time;
          cnt       <= cnt - 16'd1;
          position  <= dir ? position - 32'd1 : position + 32'd1;
          interval  <= interval + {{17{add[14]}}, add};
          pulse_cnt <= pulse_w == 8'd0 ? 8'd1 : pulse_w;
          state     <= PULSE;
        end
        default: if (pulse_cnt <= 8'd1) begin
          step      <= 1'b0;
          next_time <= last_time + interval;
          state     <= cnt != 16'd0 ? WAIT : (enable && !empty) ? LOAD : IDLE;
        end else begin
          pulse_cnt <= pulse_cnt - 8'd1;
        end
      endcase
      // emergency stop overrides everything above, keeping LAST_TIME and POSITION
      if (shutdown) begin
        state  <= IDLE;
        step   <= 1'b0;
        enable <= 1'b0;
        wp     <= '0;
        rp     <= '0;
        occ    <= '0;
      end
    end
  end
endmodule
